// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: instruction field positions,
// fetch FSM encoding and the {pc, instr} entry carried through the fetch buffer.
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order FIFO of fetched {pc, instr} entries with flush; the head entry is
// read straight out of the storage flops so decode sees registered values.
module fetch_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output fetch_entry_t                 head,
    output logic                         head_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A push into a full buffer is only accepted alongside a pop.
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: 32'h0, instr: NOP_WORD};
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// MIPS fetch stage: owns the PC, issues single-outstanding word reads and hands
// buffered instructions to decode as split fields.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_FETCH   | no request outstanding; issue at pc when buffer has room
//   ST_WAIT    | request outstanding; its ack is pushed into the buffer
//   ST_DISCARD | request outstanding but stale after a redirect; drop its ack
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm
);

    localparam int CW = $clog2(BUF_DEPTH+1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          fetch_en_q;
    logic          issue;
    logic          buf_push;
    logic          buf_pop;
    logic          buf_valid;
    logic [CW-1:0] buf_count;
    fetch_entry_t  buf_head;
    fetch_entry_t  push_entry;

    // fetch_en_q keeps imem_req low while reset is held and for the release edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= word_align(RESET_PC);
            req_pc_q   <= word_align(RESET_PC);
            fetch_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            fetch_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        issue    = 1'b0;
        buf_push = 1'b0;
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
            // An ack landing with the redirect retires the old request outright.
            unique case (state_q)
                ST_WAIT, ST_DISCARD: state_d = imem_ack ? ST_FETCH : ST_DISCARD;
                default:             state_d = ST_FETCH;
            endcase
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (fetch_en_q && (buf_count < CW'(BUF_DEPTH))) begin
                        issue    = 1'b1;
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_ack) begin
                        buf_push = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (imem_ack) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    assign imem_req   = issue;
    assign imem_addr  = pc_q;
    assign push_entry = '{pc: req_pc_q, instr: imem_rdata};
    assign buf_pop    = buf_valid && !id_stall;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (buf_push),
        .push_entry (push_entry),
        .pop        (buf_pop),
        .flush      (redirect_valid),
        .head       (buf_head),
        .head_valid (buf_valid),
        .count      (buf_count)
    );

    assign id_valid = buf_valid;
    assign id_pc    = buf_head.pc;
    assign id_instr = buf_head.instr;
    assign op       = buf_head.instr[OP_HI:OP_LO];
    assign funct    = buf_head.instr[FUNCT_HI:FUNCT_LO];
    assign rs       = buf_head.instr[RS_HI:RS_LO];
    assign rt       = buf_head.instr[RT_HI:RT_LO];
    assign rd       = buf_head.instr[RD_HI:RD_LO];
    assign imm      = buf_head.instr[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a memory responder plus a queue-level model of the
// fetch stage, compared against the DUT every falling edge.
module tb_instr_fetch;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;

    int total = 0;
    int bad   = 0;

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .op             (op),
        .funct          (funct),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .imm            (imm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return {a[17:2], a[17:2] ^ 16'h5A5A};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // memory responder and reference model state
    logic [63:0] mq[$];
    logic [31:0] addr_log[$];
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_req_pc = RST_PC;
    bit          m_out = 0;
    bit          m_stale = 0;
    int          lat = 1;
    bit          rsp_pend = 0;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = 32'h0;

    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            bit          exp_req;
            bit          pop;
            logic [63:0] e;
            @(negedge clk);
            imem_ack = 1'b0;
            if (rsp_pend) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(rsp_addr);
                    rsp_pend   = 0;
                end
            end
            if (!rst_n) begin
                chk("rst_imem_req", 64'(imem_req), 64'(0));
                chk("rst_imem_addr", 64'(imem_addr), 64'(RST_PC));
                chk("rst_id_valid", 64'(id_valid), 64'(0));
                mq.delete();
                m_pc    = RST_PC;
                m_out   = 0;
                m_stale = 0;
            end else begin
                exp_req = !m_out && (mq.size() < DEPTH) && !redirect_valid;
                chk("imem_req", 64'(imem_req), 64'(exp_req));
                if (exp_req) chk("imem_addr", 64'(imem_addr), 64'(m_pc));
                chk("id_valid", 64'(id_valid), 64'(mq.size() != 0));
                if (mq.size() != 0) begin
                    e = mq[0];
                    chk("id_pc", 64'(id_pc), 64'(e[63:32]));
                    chk("id_instr", 64'(id_instr), 64'(e[31:0]));
                    chk("id_fields", 64'({op, rs, rt, rd, funct, imm}),
                        64'({e[31:26], e[25:21], e[20:16], e[15:11], e[5:0], e[15:0]}));
                end
                pop = (mq.size() != 0) && !id_stall;
                if (redirect_valid) begin
                    mq.delete();
                    m_pc = redirect_pc & ~32'd3;
                    if (imem_ack) m_out = 0;
                    m_stale = m_out;
                end else begin
                    if (pop) void'(mq.pop_front());
                    if (m_out && imem_ack) begin
                        if (!m_stale) mq.push_back({m_req_pc, imem_rdata});
                        m_out   = 0;
                        m_stale = 0;
                    end
                    if (exp_req) begin
                        m_out    = 1;
                        m_stale  = 0;
                        m_req_pc = m_pc;
                        m_pc     = m_pc + 32'd4;
                    end
                end
            end
            if (imem_req) begin
                addr_log.push_back(imem_addr);
                rsp_pend = 1;
                rsp_cnt  = lat;
                rsp_addr = imem_addr;
            end
        end
    end

    initial begin
        int k;
        int n;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_stall       = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_req", 64'(imem_req), 64'(0));
        chk("reset_addr", 64'(imem_addr), 64'(32'h0));
        chk("reset_id_pc", 64'(id_pc), 64'(32'h0));
        chk("reset_id_instr", 64'(id_instr), 64'(32'h0));
        rst_n = 1'b1;

        // 1: first instruction and sequential addresses
        k = 0;
        while (!id_valid && k < 20) begin step(); k++; end
        if (k >= 20) tmo("t1_id_valid");
        chk("t1_op", 64'(op), 64'(6'b001000));
        chk("t1_rt", 64'(rt), 64'(8));
        chk("t1_imm", 64'(imm), 64'(5));
        chk("t1_id_pc", 64'(id_pc), 64'(0));
        repeat (8) step();
        if (addr_log.size() >= 3) begin
            chk("t1_addr0", 64'(addr_log[0]), 64'(32'h0));
            chk("t1_addr1", 64'(addr_log[1]), 64'(32'h4));
            chk("t1_addr2", 64'(addr_log[2]), 64'(32'h8));
        end else tmo("t1_addr_log");

        // 2: decode stall fills the buffer then fetch stops
        id_stall = 1'b1;
        repeat (10) step();
        chk("t2_req_stopped", 64'(imem_req), 64'(0));
        chk("t2_model_depth", 64'(mq.size()), 64'(DEPTH));
        chk("t2_id_valid", 64'(id_valid), 64'(1));
        id_stall = 1'b0;
        repeat (10) step();

        // 3: redirect while a slow request is outstanding
        lat = 5;
        k = 0;
        while (!(rsp_pend && rsp_cnt == 5) && k < 40) begin step(); k++; end
        if (k >= 40) tmo("t3_wait_state");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        n = addr_log.size();
        step();
        redirect_valid = 1'b0;
        chk("t3_id_valid_flushed", 64'(id_valid), 64'(0));
        k = 0;
        while (addr_log.size() <= n && k < 30) begin step(); k++; end
        if (k >= 30) tmo("t3_new_req");
        else chk("t3_first_addr", 64'(addr_log[n]), 64'(32'h100));
        k = 0;
        while (!id_valid && k < 30) begin step(); k++; end
        if (k >= 30) tmo("t3_id_valid");
        chk("t3_first_id_pc", 64'(id_pc), 64'(32'h100));
        repeat (12) step();

        // 4: redirect coincident with ack under stall
        lat = 1;
        k = 0;
        while (!(rsp_pend && rsp_cnt == 1) && k < 40) begin step(); k++; end
        if (k >= 40) tmo("t4_ack_due");
        id_stall       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        chk("t4_id_valid_next", 64'(id_valid), 64'(0));
        repeat (6) step();
        chk("t4_head_pc", 64'(id_pc), 64'(32'h200));
        id_stall = 1'b0;
        repeat (6) step();

        // 5: PC wrap; low redirect bits are forced to zero
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        n = addr_log.size();
        step();
        redirect_valid = 1'b0;
        k = 0;
        while (addr_log.size() < n + 2 && k < 30) begin step(); k++; end
        if (k >= 30) tmo("t5_wrap_reqs");
        else begin
            chk("t5_addr_top", 64'(addr_log[n]), 64'(32'hFFFF_FFFC));
            chk("t5_addr_wrap", 64'(addr_log[n+1]), 64'(32'h0));
        end
        repeat (6) step();

        // 6: async reset mid-request, late ack lands on the release cycle
        lat = 5;
        k = 0;
        while (!(rsp_pend && rsp_cnt == 5) && k < 40) begin step(); k++; end
        if (k >= 40) tmo("t6_wait_state");
        #1 rst_n = 1'b0;
        #1;
        chk("t6_req_async", 64'(imem_req), 64'(0));
        chk("t6_addr_async", 64'(imem_addr), 64'(RST_PC));
        chk("t6_valid_async", 64'(id_valid), 64'(0));
        chk("t6_id_instr_async", 64'(id_instr), 64'(32'h0));
        k = 0;
        while (!(rsp_pend && rsp_cnt == 1) && k < 20) begin step(); k++; end
        if (k >= 20) tmo("t6_late_ack");
        @(negedge clk);
        #1;
        lat   = 1;
        n     = addr_log.size();
        rst_n = 1'b1;
        k = 0;
        while (addr_log.size() <= n && k < 20) begin step(); k++; end
        if (k >= 20) tmo("t6_restart");
        else chk("t6_restart_addr", 64'(addr_log[n]), 64'(RST_PC));
        k = 0;
        while (!id_valid && k < 20) begin step(); k++; end
        if (k >= 20) tmo("t6_id_valid");
        chk("t6_id_pc", 64'(id_pc), 64'(32'h0));
        chk("t6_id_instr", 64'(id_instr), 64'(32'h2008_0005));
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
